mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the 4-to-1 multiplexer datapath. It shares one output channel between four requesters and drives the mux select lines S1/S0 from a registered grant. It presents a valid/ready handshake to the downstream consumer. A hold limit bounds how long one requester can keep the channel.

Parameters:
DATA_W, 8, width of each input lane and of out_data
MAX_HOLD, 4, maximum accepted beats per grant before forced rotation (1..15)

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
req  input  4  per-requester request; req[i] high means in<i> holds valid data
in0  input  DATA_W  requester 0 data
in1  input  DATA_W  requester 1 data
in2  input  DATA_W  requester 2 data
in3  input  DATA_W  requester 3 data
out_ready  input  1  downstream accepts a beat this cycle
out_valid  output  1  out_data is valid
out_data  output  DATA_W  muxed data of the granted requester
grant  output  4  one-hot grant, registered; 0000 when idle
s1  output  1  mux select MSB (granted index bit 1), registered
s0  output  1  mux select LSB (granted index bit 0), registered
busy  output  1  high while in GRANT state

Behaviour:
- Reset (sampled at posedge clock while reset=1):
  - state=IDLE, grant=0000, s1=0, s0=0, hold_cnt=0, busy=0.
  - Priority pointer last=3, so requester 0 has top priority first.
  - out_valid is therefore 0.
- Reset asserted mid-transfer aborts the grant at that posedge. No beat is accepted in that cycle.
- Arbitration (combinational pick):
  - Search req starting at index (last+1) mod 4, wrapping through 3→0.
  - The first set bit wins.
- IDLE:
  - If any req is high, register grant=onehot(win), {s1,s0}=win, hold_cnt=0, and go to GRANT. The grant appears in the next cycle (1-cycle arbitration latency).
  - Otherwise stay in IDLE.
- GRANT, with g = granted index:
  - out_valid = req[g] (combinational from the registered grant).
  - out_data = in<g>, selected by {s1,s0} through the mux. It is combinational and has no data latency.
  - A beat is accepted when out_valid && out_ready. On a beat, hold_cnt increments.
  - Release condition: req[g]==0, OR (beat && hold_cnt==MAX_HOLD-1).
  - On release, set last=g and re-arbitrate in the same cycle, excluding g only if another req is high.
    - If a winner exists, load the new grant and select, with hold_cnt=0, and stay in GRANT. There is no idle bubble.
    - If no winner exists, go to IDLE with grant=0000. {s1,s0} keeps its last value.
  - If g is the only requester at forced rotation, it is re-granted immediately with hold_cnt=0.
- Backpressure: while out_ready=0, grant, select and hold_cnt are frozen. The grant is released only if req[g] drops.
- Requesters must hold in<i> stable while req[i]=1. The block does not register data.
- grant is always one-hot or zero. {s1,s0} always encodes the grant index whenever grant≠0.
- hold_cnt width is 4 bits. It never exceeds MAX_HOLD-1.

Decomposition:
- Header mux_arb_defs.vh holds:
  - state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1
  - index constants REQ0..REQ3
- Datapath: instantiate the existing mux4_to_1 DATA_W times via generate, one per bit. The arbiter drives its S1/S0.
- No other sub-module. The round-robin pick is a function inside the arbiter.

Test Plan:
1. Reset, then req=0000 for 5 cycles → grant=0000, s1s0=00, out_valid=0, busy=0 throughout.
2. in0..in3=8'hA0,8'hB1,8'hC2,8'hD3; req=0010, out_ready=1 → grant=0010 one cycle later, s1s0=01. Then 4 beats of 8'hB1. After the 4th beat, 0010 is re-granted with hold_cnt=0.
3. req=1111, out_ready=1, MAX_HOLD=4 → grant order 0001,0010,0100,1000,0001, with 4 beats each. Data is A0×4, B1×4, C2×4, D3×4, and there are no bubble cycles between grants.
4. Grant on requester 2, out_ready=0 for 6 cycles → grant=0100, out_valid=1, out_data=8'hC2 are held and hold_cnt is unchanged. Raising out_ready resumes the beat count.
5. Requester 3 granted; drop req[3] with req=0001 pending → next cycle grant=0001, s1s0=00. With no other req pending, state goes to IDLE and grant=0000.
6. Assert reset during the 2nd beat of a grant on requester 1 → next cycle grant=0000, out_valid=0, busy=0. Re-requesting with req=1111 grants requester 0 first.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared state encoding and requester index constants
package mux4_rr_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;
  localparam logic [1:0] REQ0 = 2'd0;
  localparam logic [1:0] REQ1 = 2'd1;
  localparam logic [1:0] REQ2 = 2'd2;
  localparam logic [1:0] REQ3 = 2'd3;
endpackage

// File: rtl/mux4_rr_arbiter_mux4_to_1.sv
// mux4_to_1: single-bit 4-to-1 multiplexer steered by s1/s0
module mux4_to_1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s1,
  input  logic s0,
  output logic y
);
  assign y = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter with hold limit driving a 4-to-1 mux datapath
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        grant,
  output logic              s1,
  output logic              s0,
  output logic              busy
);
  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] hold_q, hold_d;
  logic [1:0] last_q, last_d;
  logic       beat, rel, any;
  logic [1:0] pick;

  // Search starts just after `from`; `from` itself is the last candidate.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] p;
    p = from;
    for (int k = 4; k >= 1; k--)
      if (r[2'(from + 2'(k))]) p = 2'(from + 2'(k));
    return p;
  endfunction

  assign busy      = state_q == ST_GRANT;
  assign out_valid = busy && req[sel_q];
  assign beat      = out_valid && out_ready;
  assign rel       = busy && (!req[sel_q] || (beat && hold_q == 4'(MAX_HOLD - 1)));
  assign any       = |req;
  assign pick      = rr_pick(req, busy ? sel_q : last_q);
  assign grant     = grant_q;
  assign s1        = sel_q[1];
  assign s0        = sel_q[0];

  // Next grant: arbitrate from idle or on release, otherwise count accepted beats.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    last_d  = rel ? sel_q : last_q;
    if ((!busy || rel) && any) begin
      state_d = ST_GRANT;
      grant_d = 4'b0001 << pick;
      sel_d   = pick;
      hold_d  = '0;
    end else if (rel) begin
      state_d = ST_IDLE;
      grant_d = '0;
      hold_d  = '0;
    end else if (beat) begin
      hold_d  = hold_q + 4'd1;
    end
  end

  // State registers; last starts at REQ3 so requester 0 wins first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= REQ0;
      hold_q  <= '0;
      last_q  <= REQ3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  for (genvar b = 0; b < DATA_W; b++) begin : g_mux
    mux4_to_1 u_mux (
      .i0(in0[b]),
      .i1(in1[b]),
      .i2(in2[b]),
      .i3(in3[b]),
      .s1(sel_q[1]),
      .s0(sel_q[0]),
      .y (out_data[b])
    );
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: randomized and directed checks against a behavioural round-robin model
module tb_mux4_rr_arbiter;
  localparam int MAX_HOLD = 4;
  logic       clock = 0;
  logic       reset = 1;
  logic [3:0] req = '0;
  logic       out_ready = 0;
  logic [7:0] din [4];
  logic [7:0] in0, in1, in2, in3, out_data;
  logic       out_valid, s1, s0, busy;
  logic [3:0] grant;
  int checks = 0;
  int passes = 0;
  int mg = -1;
  int mcnt = 0;
  int mlast = 3;
  int msel = 0;
  bit en = 0;

  assign in0 = din[0];
  assign in1 = din[1];
  assign in2 = din[2];
  assign in3 = din[3];

  always #5 clock = ~clock;

  mux4_rr_arbiter #(.DATA_W(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock), .reset(reset), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .grant(grant), .s1(s1), .s0(s0), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int rr(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  // Reference model: granted index (-1 idle), beats taken this grant, priority pointer.
  always @(posedge clock) begin
    if (reset) begin
      mg = -1; mcnt = 0; mlast = 3; msel = 0; en = 1;
    end else if (mg < 0) begin
      if (req != 0) begin mg = rr(req, mlast); msel = mg; mcnt = 0; end
    end else begin
      automatic bit taken = req[mg] && out_ready;
      if (!req[mg] || (taken && mcnt + 1 == MAX_HOLD)) begin
        mlast = mg;
        mcnt = 0;
        if (req != 0) begin mg = rr(req, mlast); msel = mg; end
        else mg = -1;
      end else if (taken) mcnt++;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clock) begin
    if (en) begin
      chk("grant", grant, mg < 0 ? 0 : (1 << mg));
      chk("sel", {s1, s0}, msel);
      chk("busy", busy, mg >= 0);
      chk("out_valid", out_valid, mg >= 0 && req[mg]);
      if (mg >= 0 && req[mg]) chk("out_data", out_data, din[mg]);
    end
  end

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1; req = '0; tick; reset = 0;
  endtask

  initial begin
    din[0] = 8'hA0; din[1] = 8'hB1; din[2] = 8'hC2; din[3] = 8'hD3;
    tick; tick; reset = 0;
    repeat (5) begin
      tick;
      chk("idle_grant", grant, 0); chk("idle_sel", {s1, s0}, 0);
      chk("idle_valid", out_valid, 0); chk("idle_busy", busy, 0);
    end
    req = 4'b0010; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("single_grant", grant, 4'b0010); chk("single_sel", {s1, s0}, 2'b01);
      chk("single_data", out_data, 8'hB1);
    end
    do_reset; req = 4'b1111; out_ready = 1;
    for (int k = 0; k < 17; k++) begin
      tick;
      chk("rr_grant", grant, 1 << ((k / 4) % 4));
      chk("rr_data", out_data, din[(k / 4) % 4]);
    end
    do_reset; req = 4'b0100; out_ready = 0;
    tick;
    chk("bp_grant0", grant, 4'b0100);
    req = 4'b0101;
    repeat (6) begin
      tick;
      chk("bp_grant", grant, 4'b0100); chk("bp_valid", out_valid, 1); chk("bp_data", out_data, 8'hC2);
    end
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk("bp_resume", grant, i < 4 ? 4'b0100 : 4'b0001);
    end
    do_reset; req = 4'b1000;
    tick;
    chk("drop_g3", grant, 4'b1000);
    req = 4'b0001;
    tick;
    chk("drop_next", grant, 4'b0001); chk("drop_sel", {s1, s0}, 2'b00);
    req = 4'b0000;
    tick;
    chk("drop_idle", grant, 0); chk("drop_busy", busy, 0);
    do_reset; req = 4'b0010; out_ready = 1;
    tick; tick;
    chk("mid_grant", grant, 4'b0010);
    reset = 1;
    tick;
    chk("mid_rst_grant", grant, 0); chk("mid_rst_valid", out_valid, 0); chk("mid_rst_busy", busy, 0);
    reset = 0; req = 4'b1111;
    tick;
    chk("mid_regrant", grant, 4'b0001);
    for (int c = 0; c < 3000; c++) begin
      automatic logic [3:0] nr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) nr = 4'b1111;
      for (int i = 0; i < 4; i++)
        if (!req[i]) din[i] = 8'($urandom);
      req = nr;
      out_ready = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 63) == 0;
      tick;
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
